grf_wb_arbiter: RTL
===================

// Module: grf_wb_arbiter
// PURPOSE
//  Sole write-side driver of the GRF single write port (A3/WD; A3==0 means no write).
//  Merges two producers: the W-stage pipeline write and an auxiliary multi-cycle producer
//  (MDU result move-back, later coprocessor reads).
//  Pipeline writes always win. Auxiliary writes are buffered in a small FIFO with a
//  valid/ready handshake and drain in idle cycles. Exposes a pending-write query to the
//  hazard unit so D-stage reads stall on registers still queued.
// PARAMETERS
//  DEPTH  4  aux FIFO entries; power of two, >=2
//  AW     2  log2(DEPTH), pointer width
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  pipe_a3    in   5   W-stage destination register; 0 = no write this cycle
//  pipe_wd    in   32  W-stage write data
//  aux_valid  in   1   aux producer offers a write
//  aux_ready  out  1   FIFO can accept; transfer when aux_valid&&aux_ready at posedge
//  aux_a3     in   5   aux destination register
//  aux_wd     in   32  aux write data
//  grf_a3     out  5   to GRF A3
//  grf_wd     out  32  to GRF WD
//  query_a    in   5   register number from hazard unit
//  query_hit  out  1   1 = a live queued aux write targets query_a
//  fifo_cnt   out  AW+1 number of occupied FIFO entries
// BEHAVIOUR
//  Reset: FIFO empty, wr_ptr=rd_ptr=0, fifo_cnt=0, all entry a3 fields=0. While reset
//   is high: aux_ready=0, query_hit=0, grf_a3=pipe_a3, grf_wd=pipe_wd.
//  Write-port select (combinational):
//   - pipe_a3!=0: grf_a3/grf_wd = pipe_a3/pipe_wd; no pop.
//   - else if fifo_cnt!=0: grf_a3/grf_wd = head entry; head pops at this posedge.
//   - else grf_a3=0, grf_wd=0.
//  Push: at posedge when aux_valid&&aux_ready. Entry written at wr_ptr; wr_ptr+1 mod DEPTH.
//   - aux_a3==0 is accepted and discarded: no push, count unchanged.
//  aux_ready = !reset && (fifo_cnt<DEPTH). Registered-state only; a same-cycle pop does
//   not raise ready when full.
//  Latency: an accepted aux write reaches grf_a3 no earlier than the next cycle. There is
//   no bypass from aux inputs to grf outputs.
//  Simultaneous push+pop: both occur; fifo_cnt unchanged; pointers each advance with
//   wrap-around.
//  Ordering rule: the pipeline write is architecturally younger than queued aux writes.
//   On any cycle with pipe_a3!=0, every live entry whose a3==pipe_a3 has its a3 cleared
//   to 0 (killed). A killed entry still occupies its slot. It pops as a no-op
//   (grf_a3=0) in an idle cycle.
//  Entry pushed in the same cycle with a3==pipe_a3 is NOT killed; it is younger.
//  query_hit = OR over live entries (a3!=0) of (a3==query_a), forced 0 when query_a==0.
//   Reflects state after kills of the previous cycle, not the current pipe_a3.
//  Starvation: continuous pipe writes block drain indefinitely; by design. The hazard
//   unit guarantees bubbles.
//  Reset mid-operation: queued writes are lost and outputs revert immediately.
//   In-flight aux handshake is cancelled; the producer must re-offer.
// TESTING
//  1 Reset, pipe_a3=0, aux idle -> grf_a3=0, grf_wd=0, aux_ready=1, fifo_cnt=0.
//  2 Push aux ($5,32'h11) with pipe idle -> next cycle grf_a3=5, grf_wd=32'h11.
//    Following cycle fifo_cnt=0.
//  3 Push 4 aux writes ($1..$4) while pipe_a3=$8 every cycle -> aux_ready=0,
//    fifo_cnt=4, grf_a3=8 throughout. Then pipe idle 4 cycles -> drains $1,$2,$3,$4
//    in order.
//  4 Queue ($7,32'hAA); then pipe writes ($7,32'hBB) -> query_a=7 gives query_hit=0.
//    Idle pop shows grf_a3=0. Register $7 ends at 32'hBB.
//  5 FIFO full, pipe idle, aux_valid held -> pop occurs, ready rises one cycle later.
//    Steady push+pop keeps fifo_cnt at 3/4 with pointer wrap; verify order.
//  6 Queue 2 entries, assert reset mid-cycle -> fifo_cnt=0, aux_ready=0, query_hit=0
//    immediately. After release, no stale write ever appears on grf_a3.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_arbiter
//  Description : Sole driver of the GRF write port (A3/WD, A3==0 = no write).
//                Merges the W-stage pipeline write with an auxiliary
//                multi-cycle producer (MDU move-back, coprocessor reads).
//                Pipeline writes always win; aux writes are queued in a
//                small FIFO (valid/ready) and drain in idle cycles. A
//                pending-write query lets the hazard unit stall D-stage
//                reads of registers that are still queued.
//  Ports       : clk, reset (async, active-high)
//                pipe_a3/pipe_wd            W-stage write request
//                aux_valid/aux_ready/aux_a3/aux_wd   aux producer handshake
//                grf_a3/grf_wd              to GRF write port
//                query_a/query_hit          hazard-unit pending-write query
//                fifo_cnt                   occupied FIFO entries
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    pipe_a3,
    input  logic [31:0]   pipe_wd,
    input  logic          aux_valid,
    output logic          aux_ready,
    input  logic [4:0]    aux_a3,
    input  logic [31:0]   aux_wd,
    output logic [4:0]    grf_a3,
    output logic [31:0]   grf_wd,
    input  logic [4:0]    query_a,
    output logic          query_hit,
    output logic [AW:0]   fifo_cnt
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);

    logic [4:0]    r_a3 [DEPTH];
    logic [31:0]   r_wd [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    logic          w_pipe_wr;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    assign w_pipe_wr = (pipe_a3 != 5'd0);
    // Ready depends on registered occupancy only, never on a same-cycle pop.
    assign aux_ready = !reset && (r_cnt < c_depth);
    assign w_accept  = aux_valid && aux_ready;
    // A write to $0 completes the handshake but is dropped.
    assign w_push    = w_accept && (aux_a3 != 5'd0);
    assign w_pop     = !w_pipe_wr && (r_cnt != '0);
    assign fifo_cnt  = r_cnt;

    // Write-port select: pipeline first, then FIFO head, else no write.
    always_comb begin
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        if (reset || w_pipe_wr) begin
            grf_a3 = pipe_a3;
            grf_wd = pipe_wd;
        end else if (r_cnt != '0) begin
            grf_a3 = r_a3[r_rd_ptr];
            grf_wd = r_wd[r_rd_ptr];
        end
    end

    // Free and popped slots always hold a3==0, so a non-zero a3 marks a live entry.
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((r_a3[i] != 5'd0) && (r_a3[i] == query_a)) begin
                query_hit = 1'b1;
            end
        end
        if (reset || (query_a == 5'd0)) begin
            query_hit = 1'b0;
        end
    end

    // Entry destination fields. The pushed slot is never the target of a kill
    // (push wins), which keeps a same-cycle push younger than the pipe write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a3[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == AW'(i))) begin
                    r_a3[i] <= aux_a3;
                end else if ((w_pop && (r_rd_ptr == AW'(i))) ||
                             (w_pipe_wr && (r_a3[i] == pipe_a3))) begin
                    r_a3[i] <= 5'd0;
                end
            end
        end
    end

    // Data payload needs no reset: it is only visible while a3 is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wr_ptr == AW'(i))) begin
                r_wd[i] <= aux_wd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire
